alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
Shares the single 16-bit ALU between two requesters: port 0 is the core execute stage and port 1 is the auxiliary/debug issuer.
- Arbitrates requests, latches the operands and sequences the ALU's gated clock enable.
- Captures the accumulator and flags, then returns them on one response channel tagged with the requester id.
- Sits between the decode/execute logic and the ALU instance. It is the only agent that drives the ALU's clk_enable.

Parameters:
SETTLE_CYCLES, 1, cycles alu_clk_enable is held high per operation (1..7); the ALU updates on the falling clk edge inside this window.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 accept (combinational)
req0_type  in  2  instruction type field
req0_opcode  in  5  ALU opcode
req0_r1  in  16  operand 1
req0_r2  in  16  operand 2 / immediate
req1_valid, req1_ready, req1_type, req1_opcode, req1_r1, req1_r2: same as port 0
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that owns the result
rsp_acc  out  16  captured accumulator
rsp_flags  out  4  {carry, overflow, bool, zero}
rsp_err  out  1  rejected opcode (only with the optional feature; otherwise tied 0)
alu_clk_enable  out  1  ALU clock enable
alu_type  out  2  registered operand bus to ALU
alu_opcode  out  5
alu_r1  out  16
alu_r2  out  16
alu_acc  in  16  ALU accumulator
alu_carry, alu_overflow, alu_bool, alu_zero  in  1 each  ALU flags
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, settle counter 0, last_grant=1 so port 0 wins the first tie.
- If reset arrives mid-operation, the transaction is dropped and alu_clk_enable falls immediately. No response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grant==N.
  - Round-robin grant: if both ports are valid, grant the port other than last_grant. If one port is valid, grant it.
  - FIXED_PRIO=1 grants port 0 on ties.
  - On handshake: latch type/opcode/r1/r2 into the alu_* registers, record the id, update last_grant, clear the counter, go to ISSUE.
  - Only one request is accepted per cycle.
- ISSUE:
  - alu_clk_enable=1; operands held stable. The counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, on that rising edge: capture alu_acc/flags into rsp_acc/rsp_flags, set rsp_valid=1, drop alu_clk_enable, go to RESP.
- RESP:
  - rsp_* held stable until rsp_valid & rsp_ready, then return to IDLE. rsp_valid clears on the same edge.
  - A new request is not accepted in the handshake cycle. The earliest next accept is the following cycle.
  - alu_* operand registers keep their last value until the next accept.
- Latency: accept at edge T; rsp_valid is high from edge T+SETTLE_CYCLES. Throughput is one op per SETTLE_CYCLES+2 cycles with rsp_ready=1.
- Type != 2'b00 is issued unchanged. The ALU does not update, so rsp_acc/flags return the ALU's previous values. This is intentional and matches ALU semantics.
- reqN inputs are ignored outside IDLE. Requesters must hold valid and payload until ready.

Optional Feature:
ALU_ISSUE_OPCODE_CHECK_EN
- With the macro defined:
  - In IDLE, an accepted request with type!=2'b00, or an opcode outside {00011–01111, 10000–10011, 11001}, skips ISSUE.
  - It goes directly to RESP with rsp_err=1, rsp_acc=0, rsp_flags=0. alu_clk_enable is never asserted for it.
  - rsp_valid follows at edge T+1.
- Without the macro: rsp_err is constant 0 and every request is issued.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD=5'b00011 … OP_LT=5'b11001)
  - TYPE_ALU=2'b00
  - flag bit indices (FLAG_C=3, FLAG_V=2, FLAG_B=1, FLAG_Z=0)
  - FSM state encoding
  - the legal-opcode function used by the optional check
- One sub-module, alu_rr_arb2: 2-way round-robin/fixed-priority grant logic with a last_grant register.

Test Plan:
- Port 0 ADD, r1=16'h0003, r2=16'h0004, SETTLE_CYCLES=1 -> rsp_valid at T+1, rsp_id=0, rsp_acc=16'h0007, rsp_flags=4'b0000.
- Both ports valid every cycle: p0 SUB 5,5 and p1 OR 16'h00F0,16'h000F -> grants alternate 0,1,0,1. p0 rsp_acc=0 with zero=1; p1 rsp_acc=16'h00FF.
- FIXED_PRIO=1 with both ports valid -> port 0 granted 4 consecutive times; port 1 ready stays 0.
- ADD 16'hFFFF+16'h0001, rsp_ready held low 5 cycles -> rsp_valid and rsp_acc=0 with carry=1 held stable; req1_ready=0 throughout; returns to IDLE after the handshake.
- rst asserted during ISSUE -> alu_clk_enable and busy drop with no clock edge, no rsp_valid; a subsequent port 0 MUL 3×4 returns 16'h000C.
- With ALU_ISSUE_OPCODE_CHECK_EN, opcode 5'b11111 -> rsp_err=1 at T+1, alu_clk_enable never high. Without the macro, the same request is issued and rsp_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, instruction type, flag
// bit positions, issue FSM encoding and the legal-opcode predicate.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_NOT = 5'b01001;
    localparam logic [4:0] OP_SHL = 5'b01010;
    localparam logic [4:0] OP_SHR = 5'b01011;
    localparam logic [4:0] OP_INC = 5'b01100;
    localparam logic [4:0] OP_DEC = 5'b01101;
    localparam logic [4:0] OP_MOV = 5'b01110;
    localparam logic [4:0] OP_NEG = 5'b01111;
    localparam logic [4:0] OP_EQ  = 5'b10000;
    localparam logic [4:0] OP_NE  = 5'b10001;
    localparam logic [4:0] OP_GT  = 5'b10010;
    localparam logic [4:0] OP_GE  = 5'b10011;
    localparam logic [4:0] OP_LT  = 5'b11001;

    localparam logic [1:0] TYPE_ALU = 2'b00;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_B = 1;
    localparam int FLAG_Z = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Opcodes the ALU actually implements: two contiguous ranges plus LT.
    function automatic logic is_legal_opcode(input logic [4:0] opcode);
        return ((opcode >= OP_ADD) && (opcode <= OP_NEG)) ||
               ((opcode >= OP_EQ)  && (opcode <= OP_GE))  ||
               (opcode == OP_LT);
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way request arbiter: round-robin on ties, or fixed priority to port 0.
// last_grant resets to 1 so that port 0 wins the first tie.
module alu_rr_arb2
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant
);

    logic last_grant;

    always_comb begin
        // NOTE: every path assigns grant because of this default, so no latch is inferred.
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one 16-bit ALU between the execute stage (port 0) and the debug issuer
// (port 1). Optional opcode screening is built with ALU_ISSUE_OPCODE_CHECK_EN.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit FIXED_PRIO    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_type,
    input  logic [4:0]  req0_opcode,
    input  logic [15:0] req0_r1,
    input  logic [15:0] req0_r2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_type,
    input  logic [4:0]  req1_opcode,
    input  logic [15:0] req1_r1,
    input  logic [15:0] req1_r2,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_acc,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,

    output logic        alu_clk_enable,
    output logic [1:0]  alu_type,
    output logic [4:0]  alu_opcode,
    output logic [15:0] alu_r1,
    output logic [15:0] alu_r2,
    input  logic [15:0] alu_acc,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_bool,
    input  logic        alu_zero,

    output logic        busy
);

    logic [1:0]  state;
    logic [2:0]  settle_cnt;
    logic        idle;
    logic        grant;
    logic        accept;
    logic        settle_last;
    logic        reject;

    logic [1:0]  sel_type;
    logic [4:0]  sel_opcode;
    logic [15:0] sel_r1;
    logic [15:0] sel_r2;

    assign idle        = (state == ST_IDLE);
    assign busy        = ~idle;
    assign req0_ready  = idle & ~grant;
    assign req1_ready  = idle & grant;
    assign accept      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign settle_last = (settle_cnt == 3'(SETTLE_CYCLES - 1));

    assign sel_type   = grant ? req1_type   : req0_type;
    assign sel_opcode = grant ? req1_opcode : req0_opcode;
    assign sel_r1     = grant ? req1_r1     : req0_r1;
    assign sel_r2     = grant ? req1_r2     : req0_r2;

    alu_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant  (grant)
    );

`ifdef ALU_ISSUE_OPCODE_CHECK_EN
    logic rsp_err_q;

    assign reject  = (sel_type != TYPE_ALU) || !is_legal_opcode(sel_opcode);
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= reject;
        end
    end
`else
    assign reject  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            settle_cnt     <= 3'd0;
            alu_clk_enable <= 1'b0;
            alu_type       <= 2'd0;
            alu_opcode     <= 5'd0;
            alu_r1         <= 16'd0;
            alu_r2         <= 16'd0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_acc        <= 16'd0;
            rsp_flags      <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_type   <= sel_type;
                        alu_opcode <= sel_opcode;
                        alu_r1     <= sel_r1;
                        alu_r2     <= sel_r2;
                        rsp_id     <= grant;
                        settle_cnt <= 3'd0;
                        if (reject) begin
                            // Rejected ops never reach the ALU; RESP raises rsp_valid one edge later.
                            rsp_acc   <= 16'd0;
                            rsp_flags <= 4'd0;
                            state     <= ST_RESP;
                        end else begin
                            alu_clk_enable <= 1'b1;
                            state          <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    settle_cnt <= settle_cnt + 3'd1;
                    if (settle_last) begin
                        rsp_acc                <= alu_acc;
                        rsp_flags[FLAG_C]      <= alu_carry;
                        rsp_flags[FLAG_V]      <= alu_overflow;
                        rsp_flags[FLAG_B]      <= alu_bool;
                        rsp_flags[FLAG_Z]      <= alu_zero;
                        rsp_valid              <= 1'b1;
                        alu_clk_enable         <= 1'b0;
                        state                  <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    alu_clk_enable <= 1'b0;
                    rsp_valid      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: round-robin instance (SETTLE_CYCLES=1)
// and fixed-priority instance (SETTLE_CYCLES=3) on a shared request bus.
module tb_alu_issue_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [1:0]  req0_type, req1_type;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [15:0] req0_r1, req0_r2, req1_r1, req1_r2;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_clk_enable, busy;
    logic [15:0] rsp_acc, alu_r1, alu_r2;
    logic [3:0]  rsp_flags;
    logic [1:0]  alu_type;
    logic [4:0]  alu_opcode;
    logic [15:0] m_acc = 16'd0;
    logic [3:0]  m_flags = 4'd0;

    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_err, f_alu_clk_enable, f_busy;
    logic [15:0] f_rsp_acc, f_alu_r1, f_alu_r2;
    logic [3:0]  f_rsp_flags;
    logic [1:0]  f_alu_type;
    logic [4:0]  f_alu_opcode;
    logic [15:0] f_m_acc = 16'd0;
    logic [3:0]  f_m_flags = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.SETTLE_CYCLES(1), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_type(req0_type),
        .req0_opcode(req0_opcode), .req0_r1(req0_r1), .req0_r2(req0_r2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_type(req1_type),
        .req1_opcode(req1_opcode), .req1_r1(req1_r1), .req1_r2(req1_r2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_acc(rsp_acc), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_clk_enable(alu_clk_enable), .alu_type(alu_type), .alu_opcode(alu_opcode),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_acc(m_acc),
        .alu_carry(m_flags[FLAG_C]), .alu_overflow(m_flags[FLAG_V]),
        .alu_bool(m_flags[FLAG_B]), .alu_zero(m_flags[FLAG_Z]),
        .busy(busy)
    );

    alu_issue_arbiter #(.SETTLE_CYCLES(3), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_type(req0_type),
        .req0_opcode(req0_opcode), .req0_r1(req0_r1), .req0_r2(req0_r2),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_type(req1_type),
        .req1_opcode(req1_opcode), .req1_r1(req1_r1), .req1_r2(req1_r2),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
        .rsp_acc(f_rsp_acc), .rsp_flags(f_rsp_flags), .rsp_err(f_rsp_err),
        .alu_clk_enable(f_alu_clk_enable), .alu_type(f_alu_type), .alu_opcode(f_alu_opcode),
        .alu_r1(f_alu_r1), .alu_r2(f_alu_r2), .alu_acc(f_m_acc),
        .alu_carry(f_m_flags[FLAG_C]), .alu_overflow(f_m_flags[FLAG_V]),
        .alu_bool(f_m_flags[FLAG_B]), .alu_zero(f_m_flags[FLAG_Z]),
        .busy(f_busy)
    );

    // Behavioural ALU: {carry, overflow, bool, zero, acc}, updated on falling clk while enabled.
    function automatic logic [19:0] alu_calc(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c, v, bo;
        w = 17'd0; r = 16'd0; c = 1'b0; v = 1'b0; bo = 1'b0;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            OP_MUL: r = a * b;
            OP_OR:  r = a | b;
            OP_LT: begin
                bo = (a < b);
                r  = {15'd0, bo};
            end
            default: r = 16'd0;
        endcase
        return {c, v, bo, (r == 16'd0), r};
    endfunction

    always @(negedge clk)
        if (alu_clk_enable && alu_type == TYPE_ALU)
            {m_flags, m_acc} <= alu_calc(alu_opcode, alu_r1, alu_r2);

    always @(negedge clk)
        if (f_alu_clk_enable && f_alu_type == TYPE_ALU)
            {f_m_flags, f_m_acc} <= alu_calc(f_alu_opcode, f_alu_r1, f_alu_r2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive0(input logic [1:0] t, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        req0_type = t; req0_opcode = op; req0_r1 = a; req0_r2 = b; req0_valid = 1'b1;
    endtask

    task automatic drive1(input logic [1:0] t, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        req1_type = t; req1_opcode = op; req1_r1 = a; req1_r2 = b; req1_valid = 1'b1;
    endtask

    // Advances until the round-robin instance shows rsp_valid; an expired budget is a failure.
    task automatic next_rsp();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 12);
        check("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int n;
        logic seen;
        req0_type = 2'd0; req0_opcode = 5'd0; req0_r1 = 16'd0; req0_r2 = 16'd0;
        req1_type = 2'd0; req1_opcode = 5'd0; req1_r1 = 16'd0; req1_r2 = 16'd0;

        // Reset values
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        check("rst_outputs", {rsp_valid, busy, alu_clk_enable, rsp_id, rsp_err, rsp_flags}, 0);
        check("rst_acc_ops", {rsp_acc, alu_r1}, 0);
        tick();
        rst = 1'b0;

        // Single ADD on port 0, one settle cycle
        drive0(TYPE_ALU, OP_ADD, 16'h0003, 16'h0004);
        #1;
        check("t1_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("t1_issue", {busy, alu_clk_enable, rsp_valid}, 3'b110);
        check("t1_ops", {alu_r1, alu_r2}, {16'h0003, 16'h0004});
        tick();
        check("t1_rsp", {rsp_valid, rsp_id, alu_clk_enable}, 3'b100);
        check("t1_acc", rsp_acc, 16'h0007);
        check("t1_flags", rsp_flags, 4'b0000);
        rsp_ready = 1'b1;
        tick();
        check("t1_done", {rsp_valid, busy}, 2'b00);

        // Round-robin with both ports valid every cycle
        do_reset();
        rsp_ready = 1'b1;
        drive0(TYPE_ALU, OP_SUB, 16'h0005, 16'h0005);
        drive1(TYPE_ALU, OP_OR, 16'h00F0, 16'h000F);
        for (int i = 0; i < 4; i++) begin
            next_rsp();
            check("rr_id", rsp_id, i % 2);
            check("rr_acc", rsp_acc, (i % 2) ? 16'h00FF : 16'h0000);
            check("rr_flags", rsp_flags, (i % 2) ? 4'b0000 : 4'b0001);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Fixed priority, SETTLE_CYCLES=3: port 0 wins every tie
        do_reset();
        rsp_ready = 1'b1;
        drive0(TYPE_ALU, OP_ADD, 16'h0001, 16'h0001);
        drive1(TYPE_ALU, OP_OR, 16'h0001, 16'h0002);
        seen = f_req1_ready;
        tick();
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                tick();
                n++;
                seen = seen | f_req1_ready;
            end while (!f_rsp_valid && n < 12);
            check("fp_cycles", n, (i == 0) ? 3 : 5);
            check("fp_rsp", {f_rsp_valid, f_rsp_id, f_rsp_err, f_req0_ready, f_busy}, 5'b10001);
            check("fp_acc", f_rsp_acc, 16'h0002);
        end
        check("fp_req1_never_ready", seen, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Carry-out wraps to zero; response held under backpressure
        do_reset();
        drive0(TYPE_ALU, OP_ADD, 16'hFFFF, 16'h0001);
        tick();
        req0_valid = 1'b0;
        drive1(TYPE_ALU, OP_OR, 16'h0001, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {rsp_valid, rsp_acc, rsp_flags, req1_ready, alu_clk_enable},
                  {1'b1, 16'h0000, 4'b1001, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {rsp_valid, busy, req1_ready}, 3'b001);
        tick();
        req1_valid = 1'b0;
        tick();
        check("bp_next_rsp", {rsp_valid, rsp_id, rsp_acc}, {1'b1, 1'b1, 16'h0003});
        tick();

        // Reset during ISSUE drops the transaction without a clock edge
        do_reset();
        rsp_ready = 1'b1;
        drive0(TYPE_ALU, OP_ADD, 16'h0002, 16'h0002);
        tick();
        check("mid_issue", alu_clk_enable, 1);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_async", {alu_clk_enable, busy, rsp_valid}, 3'b000);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("mid_no_rsp", {rsp_valid, busy}, 2'b00);
        drive0(TYPE_ALU, OP_MUL, 16'h0003, 16'h0004);
        tick();
        req0_valid = 1'b0;
        tick();
        check("mul_rsp", {rsp_valid, rsp_id, rsp_acc, rsp_flags}, {1'b1, 1'b0, 16'h000C, 4'b0000});
        tick();

        // Non-ALU type: issued unchanged, ALU keeps its previous result
        drive0(2'b01, OP_ADD, 16'h0007, 16'h0007);
        tick();
        req0_valid = 1'b0;
        tick();
`ifdef ALU_ISSUE_OPCODE_CHECK_EN
        check("type_rsp", {rsp_valid, rsp_err, rsp_acc, rsp_flags}, {1'b1, 1'b1, 16'h0000, 4'b0000});
`else
        check("type_rsp", {rsp_valid, rsp_err, rsp_acc, rsp_flags}, {1'b1, 1'b0, 16'h000C, 4'b0000});
`endif
        tick();

        // Unimplemented opcode
        drive0(TYPE_ALU, 5'b11111, 16'h0001, 16'h0001);
        tick();
        req0_valid = 1'b0;
`ifdef ALU_ISSUE_OPCODE_CHECK_EN
        check("badop_accept", {alu_clk_enable, rsp_valid, busy}, 3'b001);
`else
        check("badop_accept", {alu_clk_enable, rsp_valid, busy}, 3'b101);
`endif
        tick();
`ifdef ALU_ISSUE_OPCODE_CHECK_EN
        check("badop_rsp", {rsp_valid, rsp_err, alu_clk_enable, rsp_acc}, {1'b1, 1'b1, 1'b0, 16'h0000});
`else
        check("badop_rsp", {rsp_valid, rsp_err, alu_clk_enable}, 3'b100);
`endif
        tick();
        check("badop_done", {rsp_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
